// File: rtl/sensor_pkg.sv
// sensor_pkg: shared sample width, sync byte and UART FSM state type
package sensor_pkg;
  localparam int SAMPLE_W = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous push/pop FIFO with extra-bit pointers; head always visible on dout
module sample_fifo
  import sensor_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) begin
        mem[wr[AW-1:0]] <= din;
        wr <= wr + 1'b1;
      end
      if (pop && !empty) rd <= rd + 1'b1;
    end
  end
endmodule

// File: rtl/sample_uart_tx.sv
// sample_uart_tx: buffered 16-bit sample to 8N1 UART serializer, MSB byte first; SAMPLE_UART_SYNC_BYTE_EN prepends 0xA5
module sample_uart_tx
  import sensor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       update_clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       tx,
  output logic                       busy,
  output logic                       drop
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  uart_state_t state;
  logic [BW-1:0] baud;
  logic [2:0] bit_cnt;
  logic [7:0] bits;
  logic [SAMPLE_W-1:0] rest;
  logic [1:0] left;
  logic tx_q, full, empty, pop, baud_end;
  logic [SAMPLE_W-1:0] head, first_rest;
  logic [7:0] first_byte;
  logic [1:0] first_left;
  sample_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) fifo (
    .clk(update_clk), .rst(rst), .push(sample_valid), .pop(pop),
    .din(sample_in), .dout(head), .full(full), .empty(empty)
  );
`ifdef SAMPLE_UART_SYNC_BYTE_EN
  assign first_byte = SYNC_BYTE;
  assign first_rest = head;
  assign first_left = 2'd2;
`else
  assign first_byte = head[SAMPLE_W-1 -: 8];
  assign first_rest = {head[7:0], 8'h00};
  assign first_left = 2'd1;
`endif
  assign baud_end = baud == BW'(CLKS_PER_BIT - 1);
  assign pop = !empty && (state == IDLE || (state == STOP && baud_end && left == 2'd0));
  assign tx = tx_q | rst;
  assign busy = !rst && (state != IDLE || !empty);
  assign sample_ready = rst || !full;
  assign drop = sample_valid && !sample_ready;
  always_ff @(posedge update_clk) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      bits <= '0;
      rest <= '0;
      left <= '0;
      tx_q <= 1'b1;
    end else begin
      baud <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
      if (pop) begin
        state <= START;
        tx_q <= 1'b0;
        bits <= first_byte;
        rest <= first_rest;
        left <= first_left;
      end else begin
        case (state)
          START: if (baud_end) begin
            state <= DATA;
            tx_q <= bits[0];
            bits <= bits >> 1;
          end
          DATA: if (baud_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx_q <= 1'b1;
            end else begin
              tx_q <= bits[0];
              bits <= bits >> 1;
            end
          end
          STOP: if (baud_end) begin
            if (left != 2'd0) begin
              state <= START;
              tx_q <= 1'b0;
              bits <= rest[SAMPLE_W-1 -: 8];
              rest <= rest << 8;
              left <= left - 2'd1;
            end else state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sample_uart_tx.sv
// tb_sample_uart_tx: directed bench with a per-cycle line-level model and a UART byte decoder
module tb_sample_uart_tx;
  localparam int C = 4;
  localparam int D = 4;
`ifdef SAMPLE_UART_SYNC_BYTE_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  logic clk = 0, rst = 1, sample_valid = 0, started = 0;
  logic [15:0] sample_in = '0;
  logic sample_ready, tx, busy, drop;
  int n_pass = 0, n_tot = 0;

  sample_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .update_clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .tx(tx), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  logic mq[$];
  logic [15:0] pend[$];
  logic exp_tx = 1'b1, exp_busy = 1'b0;

  function automatic void load(input logic [15:0] s);
    logic [7:0] b[$];
    logic [9:0] frame;
`ifdef SAMPLE_UART_SYNC_BYTE_EN
    b.push_back(8'hA5);
`endif
    b.push_back(s[15:8]);
    b.push_back(s[7:0]);
    foreach (b[i]) begin
      frame = {1'b1, b[i], 1'b0};
      for (int k = 0; k < 10; k++) for (int r = 0; r < C; r++) mq.push_back(frame[k]);
    end
  endfunction

  always @(posedge clk) begin
    logic acc;
    if (rst) begin
      mq.delete();
      pend.delete();
    end else begin
      acc = sample_valid && pend.size() < D;
      if (mq.size() > 0) mq.delete(0);
      if (mq.size() == 0 && pend.size() > 0) load(pend.pop_front());
      if (acc) pend.push_back(sample_in);
    end
    exp_tx = mq.size() > 0 ? mq[0] : 1'b1;
    exp_busy = mq.size() > 0 || pend.size() > 0;
  end

  always @(negedge clk) if (started) begin
    chk("tx", tx, rst ? 1'b1 : exp_tx);
    chk("busy", busy, rst ? 1'b0 : exp_busy);
    chk("ready", sample_ready, rst || pend.size() < D);
    chk("drop", drop, !rst && sample_valid && pend.size() >= D);
  end

  int rc = -1;
  logic [7:0] rsh, rx_q[$];
  always @(negedge clk) begin
    if (rst) rc = -1;
    else if (rc < 0) begin
      if (tx === 1'b0) rc = 0;
    end else begin
      rc++;
      if (rc >= C && rc < 9 * C && rc % C == C / 2) rsh = {tx, rsh[7:1]};
      if (rc == 9 * C + C / 2) begin
        rx_q.push_back(rsh);
        rc = -1;
      end
    end
  end

  task automatic push(input logic [15:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < lim) begin
      n++;
      @(negedge clk);
    end
    chk("idle_timeout", n < lim, 1'b1);
  endtask

  task automatic chk_bytes(input string nm, input logic [7:0] e[$]);
    chk({nm, "_count"}, rx_q.size(), e.size());
    for (int i = 0; i < e.size() && i < rx_q.size(); i++) chk({nm, "_byte"}, rx_q[i], e[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] e[$];
    logic [5:0] rdy;
    int n, lows, drops;
    @(posedge clk);
    started = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", sample_ready, 1);
    @(posedge clk);
    #1 rx_q.delete();
    push(16'h1234);
    @(negedge clk);
    chk("t1_tx_before_pop", tx, 1);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_start_bit", tx, 0);
    wait_idle(NB * 10 * C + 20, n);
    chk("t1_len", n + 2, NB * 10 * C + 1);
    chk("t1_idle", busy, 0);
    e = '{8'h12, 8'h34};
`ifdef SAMPLE_UART_SYNC_BYTE_EN
    e.push_front(8'hA5);
`endif
    chk_bytes("t1", e);
    @(posedge clk);
    #1 rx_q.delete();
    push(16'h8000);
    push(16'hFFFF);
    wait_idle(2 * NB * 10 * C + 20, n);
    chk("t2_len", n, 2 * NB * 10 * C);
`ifdef SAMPLE_UART_SYNC_BYTE_EN
    e = '{8'hA5, 8'h80, 8'h00, 8'hA5, 8'hFF, 8'hFF};
`else
    e = '{8'h80, 8'h00, 8'hFF, 8'hFF};
`endif
    chk_bytes("t2", e);
    @(posedge clk);
    #1 rx_q.delete();
    drops = 0;
    for (int k = 0; k < 6; k++) begin
      sample_in = 16'h1100 + 16'(k);
      sample_valid = 1'b1;
      @(negedge clk);
      rdy[k] = sample_ready;
      drops += int'(drop);
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    chk("t3_ready_5th", rdy[4], 1);
    chk("t3_ready_6th", rdy[5], 0);
    chk("t3_drops", drops, 1);
    wait_idle(5 * NB * 10 * C + 40, n);
    e.delete();
    for (int k = 0; k < 5; k++) begin
`ifdef SAMPLE_UART_SYNC_BYTE_EN
      e.push_back(8'hA5);
`endif
      e.push_back(8'h11);
      e.push_back(8'(k));
    end
    chk_bytes("t3", e);
    @(posedge clk);
    #1 rx_q.delete();
    push(16'hC3A5);
    push(16'h1111);
    repeat (17) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("t4_tx", tx, 1);
    chk("t4_busy", busy, 0);
    chk("t4_ready", sample_ready, 1);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      lows += int'(!tx);
    end
    chk("t4_low_cycles", lows, 0);
    chk("t4_bytes", rx_q.size(), 0);
    @(posedge clk);
    #1 rx_q.delete();
    push(16'h00FF);
    wait_idle(NB * 10 * C + 20, n);
    chk("t5_len", n, NB * 10 * C + 1);
    e = '{8'h00, 8'hFF};
`ifdef SAMPLE_UART_SYNC_BYTE_EN
    e.push_front(8'hA5);
`endif
    chk_bytes("t5", e);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
